mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO result registers, the multi-cycle companion to the single-cycle `alu` in the MIPS pipeline. Accepts one operation at a time from the EX stage. Computes it over a fixed number of cycles using radix-2 shift-add (multiply) or restoring (divide) iteration. Holds the result in HI/LO, and exposes `busy` so the hazard unit can stall MFHI/MFLO and any new multiply/divide.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `start`  input  1  launch operation; sampled only when `busy`=0.
- `op`  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a`  input  WIDTH  multiplicand or dividend (rs).
- `b`  input  WIDTH  multiplier or divisor (rt).
- `hiwe`  input  1  MTHI: write `wd` to HI; honoured only when `busy`=0.
- `lowe`  input  1  MTLO: write `wd` to LO; honoured only when `busy`=0.
- `wd`  input  WIDTH  MTHI/MTLO write data.
- `busy`  output  1  operation in flight; hazard unit stalls on it.
- `done`  output  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  output  WIDTH  HI register; product upper half or remainder.
- `lo`  output  WIDTH  LO register; product lower half or quotient.

## Operation
- States: IDLE, CALC, FIX. All outputs are registered.
- IDLE: when `start`=1, latch `op`, the operand magnitudes and the result sign flags, clear the iteration counter, and go to CALC.
  - Magnitudes are two's-complement absolute values for signed ops and the raw operands for unsigned ops.
  - Multiply sign: negative iff the operand signs differ.
  - Quotient sign: negative iff the operand signs differ. Remainder sign: same as the dividend.
- CALC: exactly `WIDTH` iterations, one per cycle, counter from 0 to `WIDTH`-1. Then go to FIX.
  - Multiply: 2·`WIDTH`-bit shift-add accumulator.
  - Divide: restoring shift-subtract with a `WIDTH`+1-bit partial remainder.
- FIX: apply the sign correction, write HI/LO, and go to IDLE.
  - Multiply negation is over the full 2·`WIDTH` bits.
- Divide by zero (`b`=0 at start), fixed behaviour with no special timing:
  - DIVU: LO = all ones, HI = `a`.
  - DIV: the unsigned-magnitude result is sign-corrected as above. The quotient is negated iff `a`<0, and HI = `a`.
- Signed overflow, DIV of MIN by -1: LO = MIN, HI = 0. No trap.
- `start` while `busy`=1: ignored. No queueing.
- `hiwe`/`lowe` while `busy`=1: ignored.
- `hiwe`/`lowe` in IDLE together with `start`: the write occurs, then the operation result overwrites HI and LO at FIX.
- `hiwe` and `lowe` together: both registers are written.
- `reset` at any time, including mid-CALC: state IDLE, `busy`=0, `done`=0, `hi`=`lo`=0, counter 0. The partial result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Edge E0 samples `start`; `busy` rises after E0.
- CALC occupies edges E1..E`WIDTH`; FIX occupies edge E`WIDTH`+1.
- After E`WIDTH`+1: `hi`/`lo` are valid, `done`=1 for exactly one cycle, and `busy`=0.
- Fixed latency: `WIDTH`+1 cycles of `busy`, for every op and operand value including divide by zero.
- A new `start` is accepted in the same cycle that `done`=1, giving back-to-back operations. That next start's E0 is the edge that ends the `done` pulse.
- MTHI/MTLO take effect after one edge; `hi`/`lo` show the new value the next cycle.
- `hi`/`lo` change only at FIX, on a MTHI/MTLO write, or on reset. They are never disturbed during CALC.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `busy` high for 33 cycles, `done` pulses once, HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x00001234 with the same 33-cycle latency. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI wd=0xAAAA5555 in idle -> HI=0xAAAA5555 next cycle. Then start DIVU 100/7; pulse `hiwe` and `start` mid-CALC -> both ignored, final HI=2, LO=14, single `done`.
- Assert `reset` asynchronously at iteration 10 of a MULT -> `busy`, `done`, `hi`, `lo` all 0 immediately. A fresh MULTU 6×7 afterwards -> LO=42, HI=0.
- Back-to-back: assert `start` in the `done` cycle, then repeat with `WIDTH`=8 and random operands against a reference model -> the second result is correct, `busy` is low for only the single `done` cycle, and 9-cycle latency is observed at `WIDTH`=8.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, fixed WIDTH+1 cycle latency.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hiwe,
  input  logic             i_lowe,
  input  logic [WIDTH-1:0] i_wd,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned RW = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_busy_nx;
  logic             w_done_nx;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;

  logic             w_load;
  logic             w_last;

  // Operand conditioning at launch: magnitudes and result sign flags
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_b[WIDTH-1];
  assign w_mag_a  = w_a_neg ? (WIDTH'(0) - i_a) : i_a;
  assign w_mag_b  = w_b_neg ? (WIDTH'(0) - i_b) : i_b;

  // Multiply step: add multiplicand into the upper half when LSB set, then shift right
  logic [RW-1:0] w_mul_sum;
  logic [AW-1:0] w_mul_step;

  assign w_mul_sum  = r_acc[AW-1:WIDTH] + {1'b0, r_opnd};
  assign w_mul_step = r_acc[0] ? ({w_mul_sum, r_acc[WIDTH-1:0]} >> 1) : (r_acc >> 1);

  // Divide step: upper RW bits hold the partial remainder, lower WIDTH bits the dividend/quotient
  logic [RW-1:0] w_shift;
  logic [RW-1:0] w_diff;
  logic [AW-1:0] w_div_step;

  assign w_shift    = {r_acc[PW-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_opnd};
  assign w_div_step = w_diff[WIDTH] ? {w_shift, r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff,  r_acc[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_prod     = r_acc[PW-1:0];
  assign w_prod_fix = r_neg_q ? (PW'(0) - w_prod) : w_prod;
  assign w_quo_fix  = r_neg_q ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? (WIDTH'(0) - r_acc[PW-1:WIDTH]) : r_acc[PW-1:WIDTH];

  assign w_load = (r_state == S_IDLE) && i_start;
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nx = S_CALC;
      S_CALC:  if (w_last)  w_state_nx = S_FIX;
      S_FIX:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nx = 1'b0;
    w_done_nx = 1'b0;
    w_hi_nx   = r_hi;
    w_lo_nx   = r_lo;
    case (r_state)
      S_IDLE: begin
        w_busy_nx = i_start;
        if (i_hiwe) w_hi_nx = i_wd;
        if (i_lowe) w_lo_nx = i_wd;
      end
      S_CALC: begin
        w_busy_nx = 1'b1;
      end
      S_FIX: begin
        w_done_nx = 1'b1;
        if (r_is_div) begin
          w_hi_nx = w_rem_fix;
          w_lo_nx = w_quo_fix;
        end else begin
          w_hi_nx = w_prod_fix[PW-1:WIDTH];
          w_lo_nx = w_prod_fix[WIDTH-1:0];
        end
      end
      default: begin
        w_busy_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= w_busy_nx;
      r_done <= w_done_nx;
      r_hi   <= w_hi_nx;
      r_lo   <= w_lo_nx;
    end
  end

  // Iteration datapath
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_load) begin
      r_cnt    <= '0;
      r_is_div <= i_op[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_opnd   <= i_op[1] ? w_mag_b : w_mag_a;
      r_acc    <= {RW'(0), (i_op[1] ? w_mag_a : w_mag_b)};
    end else if (r_state == S_CALC) begin
      r_cnt <= w_last ? CW'(0) : (r_cnt + CW'(1));
      r_acc <= r_is_div ? w_div_step : w_mul_step;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: a 32-bit instance for directed cases and
// an 8-bit instance for randomised back-to-back operations.
module tb_mdu_iter;

  logic clk;
  logic rst;

  logic        s_start, s_hiwe, s_lowe;
  logic [1:0]  s_op;
  logic [31:0] s_a, s_b, s_wd;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  logic        t_start, t_hiwe, t_lowe;
  logic [1:0]  t_op;
  logic [7:0]  t_a, t_b, t_wd;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_tests;
  int n_fail;

  logic [63:0] q32[$];
  logic [15:0] q8[$];

  mdu_iter #(.WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_op(s_op), .i_a(s_a), .i_b(s_b),
    .i_hiwe(s_hiwe), .i_lowe(s_lowe), .i_wd(s_wd),
    .o_busy(busy32), .o_done(done32), .o_hi(hi32), .o_lo(lo32)
  );

  mdu_iter #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_start(t_start), .i_op(t_op), .i_a(t_a), .i_b(t_b),
    .i_hiwe(t_hiwe), .i_lowe(t_lowe), .i_wd(t_wd),
    .o_busy(busy8), .o_done(done8), .o_hi(hi8), .o_lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: returns {hi, lo} each zero-extended to 32 bits
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    logic [63:0] mask, ua, ub, pu, hi, lo;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    hi = 64'd0;
    lo = 64'd0;
    case (op)
      2'd0: begin pu = 64'(sa * sb); hi = (pu >> w) & mask; lo = pu & mask; end
      2'd1: begin pu = ua * ub;      hi = (pu >> w) & mask; lo = pu & mask; end
      2'd2: begin
        if (sb == 0) begin
          lo = (sa < 0) ? 64'd1 : mask;
          hi = ua;
        end else begin
          q = sa / sb;
          r = sa % sb;
          lo = 64'(q) & mask;
          hi = 64'(r) & mask;
        end
      end
      default: begin
        if (ub == 64'd0) begin lo = mask; hi = ua; end
        else begin lo = ua / ub; hi = ua % ub; end
      end
    endcase
    return {hi[31:0], lo[31:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    s_start = 1'b1; s_op = op; s_a = a; s_b = b;
    q32.push_back(exp);
    tick();
    s_start = 1'b0;
  endtask

  task automatic wait32(output int n, output bit ok);
    n = 0;
    while (busy32 && n < 100) begin n++; tick(); end
    ok = !busy32;
  endtask

  task automatic wait8(output int n, output bit ok);
    n = 0;
    while (busy8 && n < 100) begin n++; tick(); end
    ok = !busy8;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    n_tests++; if ({busy32, done32} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {busy32, done32}); end
    n_tests++; if ({hi32, lo32} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {hi32, lo32}); end
    n_tests++; if ({busy8, done8, hi8, lo8} !== 18'd0) begin n_fail++; $display("FAIL reset_w8: got %h want 0", {busy8, done8, hi8, lo8}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_multu;
    int n; bit ok; logic [63:0] exp;
    start32(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    wait32(n, ok);
    n_tests++; if (!ok || n != 33) begin n_fail++; $display("FAIL multu_latency: got %0d want 33", n); end
    n_tests++; if (done32 !== 1'b1) begin n_fail++; $display("FAIL multu_done: got %b want 1", done32); end
    exp = q32.pop_front();
    n_tests++; if ({hi32, lo32} !== exp) begin n_fail++; $display("FAIL multu_result: got %h want %h", {hi32, lo32}, exp); end
    tick();
    n_tests++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done32); end
  endtask

  task automatic test_signed_and_div_corners;
    logic [1:0]  ops  [5] = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd2};
    logic [31:0] as   [5] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00001234, 32'h80000000, 32'hFFFFFFFB};
    logic [31:0] bs   [5] = '{32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [63:0] exps [5] = '{{32'hFFFFFFFF, 32'hFFFFFFEB}, {32'hFFFFFFFF, 32'hFFFFFFFD},
                              {32'h00001234, 32'hFFFFFFFF}, {32'h00000000, 32'h80000000},
                              {32'hFFFFFFFB, 32'h00000001}};
    int n; bit ok; logic [63:0] exp;
    for (int i = 0; i < 5; i++) begin
      start32(ops[i], as[i], bs[i], exps[i]);
      wait32(n, ok);
      n_tests++; if (!ok || n != 33 || done32 !== 1'b1) begin n_fail++; $display("FAIL corner%0d_timing: got lat %0d done %b want 33 1", i, n, done32); end
      exp = q32.pop_front();
      n_tests++; if ({hi32, lo32} !== exp) begin n_fail++; $display("FAIL corner%0d_result: got %h want %h", i, {hi32, lo32}, exp); end
    end
  endtask

  task automatic test_mt_and_ignore;
    int n; bit ok; int dones; logic [63:0] exp;
    s_wd = 32'h12345678; s_hiwe = 1'b1; s_lowe = 1'b1;
    tick();
    s_hiwe = 1'b0; s_lowe = 1'b0;
    n_tests++; if ({hi32, lo32} !== {32'h12345678, 32'h12345678}) begin n_fail++; $display("FAIL mt_both: got %h want 1234567812345678", {hi32, lo32}); end
    s_wd = 32'hAAAA5555; s_hiwe = 1'b1;
    tick();
    s_hiwe = 1'b0;
    n_tests++; if ({hi32, lo32} !== {32'hAAAA5555, 32'h12345678}) begin n_fail++; $display("FAIL mthi: got %h want aaaa555512345678", {hi32, lo32}); end
    start32(2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    repeat (5) tick();
    s_hiwe = 1'b1; s_wd = 32'hDEADBEEF; s_start = 1'b1; s_op = 2'd1; s_a = 32'd9; s_b = 32'd9;
    tick();
    s_hiwe = 1'b0; s_start = 1'b0;
    n_tests++; if ({busy32, hi32, lo32} !== {1'b1, 32'hAAAA5555, 32'h12345678}) begin n_fail++; $display("FAIL calc_hold: got %h want 1aaaa555512345678", {busy32, hi32, lo32}); end
    wait32(n, ok);
    n_tests++; if (!ok || n != 27 || done32 !== 1'b1) begin n_fail++; $display("FAIL ignore_timing: got rem %0d done %b want 27 1", n, done32); end
    exp = q32.pop_front();
    n_tests++; if ({hi32, lo32} !== exp) begin n_fail++; $display("FAIL ignore_result: got %h want %h", {hi32, lo32}, exp); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done32 || busy32) dones++; end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL single_done: got %0d extra busy/done cycles want 0", dones); end
  endtask

  task automatic test_mt_with_start;
    int n; bit ok; logic [63:0] exp;
    s_hiwe = 1'b1; s_lowe = 1'b1; s_wd = 32'h00000055;
    start32(2'd1, 32'd3, 32'd5, {32'd0, 32'd15});
    s_hiwe = 1'b0; s_lowe = 1'b0;
    n_tests++; if ({hi32, lo32} !== {32'h55, 32'h55}) begin n_fail++; $display("FAIL mt_start_write: got %h want 5500000055", {hi32, lo32}); end
    wait32(n, ok);
    exp = q32.pop_front();
    n_tests++; if (!ok || {hi32, lo32} !== exp) begin n_fail++; $display("FAIL mt_start_result: got %h want %h", {hi32, lo32}, exp); end
  endtask

  task automatic test_reset_mid;
    int n; bit ok; logic [63:0] exp;
    s_start = 1'b1; s_op = 2'd0; s_a = 32'h00012345; s_b = 32'hFFFF0003;
    tick();
    s_start = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({busy32, done32, hi32, lo32} !== 66'd0) begin n_fail++; $display("FAIL async_reset: got %h want 0", {busy32, done32, hi32, lo32}); end
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if ({busy32, done32} !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle: got %b want 00", {busy32, done32}); end
    start32(2'd1, 32'd6, 32'd7, {32'd0, 32'd42});
    wait32(n, ok);
    exp = q32.pop_front();
    n_tests++; if (!ok || n != 33 || {hi32, lo32} !== exp) begin n_fail++; $display("FAIL fresh_multu: got lat %0d %h want 33 %h", n, {hi32, lo32}, exp); end
  endtask

  task automatic test_back_to_back;
    int n; bit ok; logic [63:0] exp;
    start32(2'd3, 32'd1000, 32'd3, {32'd1, 32'd333});
    wait32(n, ok);
    exp = q32.pop_front();
    n_tests++; if (!ok || done32 !== 1'b1 || {hi32, lo32} !== exp) begin n_fail++; $display("FAIL b2b_first: got %h done %b want %h", {hi32, lo32}, done32, exp); end
    start32(2'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, {32'd0, 32'd6});
    n_tests++; if (busy32 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_gap: got %b want 1", busy32); end
    wait32(n, ok);
    exp = q32.pop_front();
    n_tests++; if (!ok || n != 33 || {hi32, lo32} !== exp) begin n_fail++; $display("FAIL b2b_second: got lat %0d %h want 33 %h", n, {hi32, lo32}, exp); end
  endtask

  task automatic test_back_to_back_w8;
    int n; bit ok; logic [15:0] exp; logic [63:0] m;
    for (int k = 0; k < 24; k++) begin
      t_op = 2'($urandom_range(0, 3));
      t_a  = 8'($urandom);
      t_b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      if (k == 3) begin t_op = 2'd2; t_a = 8'h80; t_b = 8'hFF; end
      if (k == 4) begin t_op = 2'd0; t_a = 8'h80; t_b = 8'h80; end
      m = ref_model(t_op, {24'd0, t_a}, {24'd0, t_b}, 8);
      q8.push_back({m[39:32], m[7:0]});
      t_start = 1'b1;
      tick();
      t_start = 1'b0;
      n_tests++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL w8_busy%0d: got %b want 1", k, busy8); end
      wait8(n, ok);
      n_tests++; if (!ok || n != 9 || done8 !== 1'b1) begin n_fail++; $display("FAIL w8_timing%0d: got lat %0d done %b want 9 1", k, n, done8); end
      exp = q8.pop_front();
      n_tests++; if ({hi8, lo8} !== exp) begin n_fail++; $display("FAIL w8_result%0d: op %0d a %h b %h got %h want %h", k, t_op, t_a, t_b, {hi8, lo8}, exp); end
    end
    tick();
    n_tests++; if ({busy8, done8} !== 2'b00) begin n_fail++; $display("FAIL w8_idle: got %b want 00", {busy8, done8}); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    s_start = 1'b0; s_hiwe = 1'b0; s_lowe = 1'b0; s_op = 2'd0; s_a = '0; s_b = '0; s_wd = '0;
    t_start = 1'b0; t_hiwe = 1'b0; t_lowe = 1'b0; t_op = 2'd0; t_a = '0; t_b = '0; t_wd = '0;
    test_reset();
    test_multu();
    test_signed_and_div_corners();
    test_mt_and_ignore();
    test_mt_with_start();
    test_reset_mid();
    test_back_to_back();
    test_back_to_back_w8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
